// File: rtl/fp_sqrt_mant_pkg.sv
// -----------------------------------------------------------------------------
// fp_sqrt_mant_pkg
// Shared constants for the mantissa square-root unit.
// This package holds the FSM state encoding, the default widths and the bit
// positions inside the {guard, round, sticky} field.
// -----------------------------------------------------------------------------
package fp_sqrt_mant_pkg;

    // Mantissa width including the hidden bit.
    localparam int MANT_W_DEF = 24;
    // Root bits produced: mantissa + guard + round.
    localparam int ITER_DEF   = MANT_W_DEF + 2;

    // Layout of the rounding-information field handed downstream.
    localparam int GRS_W      = 3;
    localparam int GRS_GUARD  = 2;
    localparam int GRS_ROUND  = 1;
    localparam int GRS_STICKY = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } sqrt_state_t;

endpackage : fp_sqrt_mant_pkg

// File: rtl/fp_sqrt_mant_if.sv
// -----------------------------------------------------------------------------
// fp_sqrt_mant_if
// Request/result bundle of the mantissa square-root unit.
//   start_i   : request, sampled only while the unit is idle
//   flush_i   : synchronous abort of an operation in progress
//   mant_i    : normalized operand 1.f (MSB = 1)
//   exp_odd_i : unbiased exponent is odd, so the radicand is doubled
//   busy_o    : operation in flight (CALC or DONE)
//   done_o    : one-cycle result-valid pulse
//   root_o    : truncated root 1.f
//   grs_o     : {guard, round, sticky} for the rounding stage
// master = requester, slave = fp_sqrt_mant.
// -----------------------------------------------------------------------------
interface fp_sqrt_mant_if
    import fp_sqrt_mant_pkg::*;
#(
    parameter int MANT_W = MANT_W_DEF
);
    logic              start_i;
    logic              flush_i;
    logic [MANT_W-1:0] mant_i;
    logic              exp_odd_i;
    logic              busy_o;
    logic              done_o;
    logic [MANT_W-1:0] root_o;
    logic [GRS_W-1:0]  grs_o;

    modport master (
        output start_i, flush_i, mant_i, exp_odd_i,
        input  busy_o, done_o, root_o, grs_o
    );

    modport slave (
        input  start_i, flush_i, mant_i, exp_odd_i,
        output busy_o, done_o, root_o, grs_o
    );

endinterface : fp_sqrt_mant_if

// File: rtl/fp_sqrt_step.sv
// -----------------------------------------------------------------------------
// fp_sqrt_step
// One restoring digit-recurrence step of the square root, purely combinational.
//   rem_i  : partial remainder so far
//   root_i : partial root so far (right-aligned)
//   pair_i : next two radicand bits, MSB first
//   rem_o  : remainder after this step
//   root_o : partial root with the new bit shifted in at the LSB
// -----------------------------------------------------------------------------
module fp_sqrt_step #(
    parameter int ITER  = 26,
    parameter int REM_W = ITER + 2
) (
    input  logic [REM_W-1:0] rem_i,
    input  logic [ITER-1:0]  root_i,
    input  logic [1:0]       pair_i,
    output logic [REM_W-1:0] rem_o,
    output logic [ITER-1:0]  root_o
);
    localparam int TRIAL_W = REM_W + 3;

    logic [TRIAL_W-1:0] trial;
    logic               root_bit;
    logic [1:0]         unused_trial_hi;

    // The extra zero MSB turns the top bit of the difference into a sign bit,
    // so a negative trial shows up as a 1 there.
    assign trial    = {1'b0, rem_i, pair_i} - {3'b000, root_i, 2'b01};
    assign root_bit = ~trial[TRIAL_W-1];

    // A non-negative trial is bounded by 2*root, so it always fits in REM_W.
    // Its upper magnitude bits are zero and are not needed.
    assign unused_trial_hi = trial[TRIAL_W-2:TRIAL_W-3];

    // On a rejected bit the old remainder keeps going with the new pair.
    // The dropped MSBs are zero because {rem, pair} < {root, 01} there.
    assign rem_o  = root_bit ? trial[REM_W-1:0] : {rem_i[REM_W-3:0], pair_i};
    assign root_o = {root_i[ITER-2:0], root_bit};

endmodule : fp_sqrt_step

// File: rtl/fp_sqrt_mant.sv
// -----------------------------------------------------------------------------
// fp_sqrt_mant
// Iterative mantissa square root. The unit produces one root bit per cycle
// using a restoring recurrence.
//   clk_i   : clock, all state updates on the rising edge
//   reset_i : asynchronous active-low reset
//   bus     : fp_sqrt_mant_if.slave. Its MANT_W must match this module's.
// A request accepted in IDLE spends ITER cycles in CALC. It then spends one
// cycle in DONE, with done_o high, and returns to IDLE. Results stay on
// root_o/grs_o until the next operation completes.
// -----------------------------------------------------------------------------
module fp_sqrt_mant
    import fp_sqrt_mant_pkg::*;
#(
    parameter int MANT_W = MANT_W_DEF,
    parameter int ITER   = MANT_W + 2
) (
    input  logic            clk_i,
    input  logic            reset_i,
    fp_sqrt_mant_if.slave   bus
);
    localparam int RAD_W = 2 * ITER;
    localparam int REM_W = ITER + 2;
    localparam int CNT_W = $clog2(ITER);

    sqrt_state_t        state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [RAD_W-1:0]   rad_q;
    logic [REM_W-1:0]   rem_q;
    logic [ITER-1:0]    root_q;
    logic               busy_q;
    logic               done_q;
    logic [MANT_W-1:0]  root_out_q;
    logic [GRS_W-1:0]   grs_q;

    logic [RAD_W-1:0]   rad_load;
    logic [REM_W-1:0]   rem_nxt;
    logic [ITER-1:0]    root_nxt;
    logic [GRS_W-1:0]   grs_nxt;

    // The radicand has two integer bits. An odd exponent doubles it by
    // placing the hidden bit in the 2^1 position.
    assign rad_load = bus.exp_odd_i
                    ? {bus.mant_i, {(RAD_W - MANT_W){1'b0}}}
                    : {1'b0, bus.mant_i, {(RAD_W - MANT_W - 1){1'b0}}};

    fp_sqrt_step #(
        .ITER  (ITER),
        .REM_W (REM_W)
    ) u_step (
        .rem_i  (rem_q),
        .root_i (root_q),
        .pair_i (rad_q[RAD_W-1 -: 2]),
        .rem_o  (rem_nxt),
        .root_o (root_nxt)
    );

    // NOTE: every signal written in always_comb gets a default first, so an
    // incomplete assignment can never infer a latch.
    always_comb begin
        grs_nxt             = '0;
        grs_nxt[GRS_GUARD]  = root_nxt[ITER-MANT_W-1];
        grs_nxt[GRS_ROUND]  = root_nxt[ITER-MANT_W-2];
        grs_nxt[GRS_STICKY] = |rem_nxt;
    end

    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples pre-edge values regardless of statement order.
    // The datapath registers are small flops rather than a memory, so they
    // all take the asynchronous reset.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rad_q      <= '0;
            rem_q      <= '0;
            root_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            root_out_q <= '0;
            grs_q      <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    // A flush in the same cycle as a start cancels the request.
                    if (bus.start_i && !bus.flush_i) begin
                        state_q <= ST_CALC;
                        busy_q  <= 1'b1;
                        cnt_q   <= CNT_W'(ITER - 1);
                        rad_q   <= rad_load;
                        rem_q   <= '0;
                        root_q  <= '0;
                    end
                end
                ST_CALC: begin
                    if (bus.flush_i) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        rad_q  <= rad_q << 2;
                        rem_q  <= rem_nxt;
                        root_q <= root_nxt;
                        if (cnt_q == '0) begin
                            // The final step is taken on this edge, so the
                            // result is published straight from the step outputs.
                            state_q    <= ST_DONE;
                            done_q     <= 1'b1;
                            root_out_q <= root_nxt[ITER-1 -: MANT_W];
                            grs_q      <= grs_nxt;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    // A flush here ends up in the same place.
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy_o = busy_q;
    assign bus.done_o = done_q;
    assign bus.root_o = root_out_q;
    assign bus.grs_o  = grs_q;

endmodule : fp_sqrt_mant

// File: tb/tb_fp_sqrt_mant.sv
// -----------------------------------------------------------------------------
// tb_fp_sqrt_mant
// Directed bench for fp_sqrt_mant, using hand-computed square roots.
// Inputs change 1 time unit after a rising edge. Outputs are read at that
// same point, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_fp_sqrt_mant;
    import fp_sqrt_mant_pkg::*;

    localparam int MW = 24;

    logic clk_i   = 1'b0;
    logic reset_i = 1'b1;

    int checks   = 0;
    int failures = 0;

    fp_sqrt_mant_if #(.MANT_W(MW)) bus ();

    fp_sqrt_mant #(.MANT_W(MW)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Asynchronous reset, then release just before the first request edge.
    task automatic test_reset();
        bus.start_i   = 1'b0;
        bus.flush_i   = 1'b0;
        bus.mant_i    = '0;
        bus.exp_odd_i = 1'b0;
        #1 reset_i = 1'b0;
        #1;
        checks++;
        if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl busy=%b done=%b want 0 0", bus.busy_o, bus.done_o);
        end
        checks++;
        if (bus.root_o !== 24'h0 || bus.grs_o !== 3'b000) begin
            failures++;
            $display("FAIL reset_data root=%h grs=%b want 000000 000", bus.root_o, bus.grs_o);
        end
        tick();
        tick();
        checks++;
        if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold busy=%b done=%b want 0 0", bus.busy_o, bus.done_o);
        end
        reset_i = 1'b1;
    endtask

    // Known roots. The first request starts on the first edge after reset release.
    task automatic test_vectors();
        logic [23:0] v_mant [4];
        logic        v_odd  [4];
        logic [23:0] v_root [4];
        logic [2:0]  v_grs  [4];
        v_mant[0] = 24'h800000; v_odd[0] = 1'b0; v_root[0] = 24'h800000; v_grs[0] = 3'b000;
        v_mant[1] = 24'h800000; v_odd[1] = 1'b1; v_root[1] = 24'hB504F3; v_grs[1] = 3'b001;
        v_mant[2] = 24'h900000; v_odd[2] = 1'b1; v_root[2] = 24'hC00000; v_grs[2] = 3'b000;
        v_mant[3] = 24'hC80000; v_odd[3] = 1'b0; v_root[3] = 24'hA00000; v_grs[3] = 3'b000;
        for (int v = 0; v < 4; v++) begin
            logic [23:0] prev_root;
            logic [2:0]  prev_grs;
            int          early;
            int          moved;
            bus.mant_i    = v_mant[v];
            bus.exp_odd_i = v_odd[v];
            bus.start_i   = 1'b1;
            tick();
            bus.start_i = 1'b0;
            checks++;
            if (bus.busy_o !== 1'b1) begin
                failures++;
                $display("FAIL vec%0d_busy busy=%b want 1", v, bus.busy_o);
            end
            prev_root = bus.root_o;
            prev_grs  = bus.grs_o;
            early     = 0;
            moved     = 0;
            for (int c = 1; c < 26; c++) begin
                tick();
                if (bus.done_o !== 1'b0) early++;
                if (bus.root_o !== prev_root || bus.grs_o !== prev_grs) moved++;
            end
            checks++;
            if (early != 0) begin
                failures++;
                $display("FAIL vec%0d_early_done pulses=%0d want 0", v, early);
            end
            checks++;
            if (moved != 0) begin
                failures++;
                $display("FAIL vec%0d_calc_stable changes=%0d want 0", v, moved);
            end
            tick();
            checks++;
            if (bus.done_o !== 1'b1) begin
                failures++;
                $display("FAIL vec%0d_done done=%b want 1", v, bus.done_o);
            end
            checks++;
            if (bus.root_o !== v_root[v]) begin
                failures++;
                $display("FAIL vec%0d_root root=%h want %h", v, bus.root_o, v_root[v]);
            end
            checks++;
            if (bus.grs_o !== v_grs[v]) begin
                failures++;
                $display("FAIL vec%0d_grs grs=%b want %b", v, bus.grs_o, v_grs[v]);
            end
            tick();
            checks++;
            if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) begin
                failures++;
                $display("FAIL vec%0d_idle done=%b busy=%b want 0 0", v, bus.done_o, bus.busy_o);
            end
        end
    endtask

    // A second start at cycle 10 is dropped. Only sqrt(2) must come out.
    task automatic test_start_ignored();
        int          dones;
        logic [23:0] got_root;
        logic [2:0]  got_grs;
        dones    = 0;
        got_root = '0;
        got_grs  = '0;
        bus.mant_i    = 24'h800000;
        bus.exp_odd_i = 1'b1;
        bus.start_i   = 1'b1;
        tick();
        bus.start_i = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 10) begin
                bus.mant_i    = 24'hC80000;
                bus.exp_odd_i = 1'b0;
                bus.start_i   = 1'b1;
            end
            if (i == 11) bus.start_i = 1'b0;
            if (bus.done_o === 1'b1) begin
                dones++;
                got_root = bus.root_o;
                got_grs  = bus.grs_o;
            end
        end
        checks++;
        if (dones != 1) begin
            failures++;
            $display("FAIL ignore_done_count dones=%0d want 1", dones);
        end
        checks++;
        if (got_root !== 24'hB504F3 || got_grs !== 3'b001) begin
            failures++;
            $display("FAIL ignore_result root=%h grs=%b want b504f3 001", got_root, got_grs);
        end
        checks++;
        if (bus.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL ignore_idle busy=%b want 0", bus.busy_o);
        end
    endtask

    // A flush at CALC cycle 5 aborts. The sqrt(2) result must survive.
    task automatic test_flush();
        int dones;
        dones = 0;
        bus.mant_i    = 24'h900000;
        bus.exp_odd_i = 1'b1;
        bus.start_i   = 1'b1;
        tick();
        bus.start_i = 1'b0;
        for (int i = 1; i <= 5; i++) tick();
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        checks++;
        if (bus.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_busy busy=%b want 0", bus.busy_o);
        end
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.done_o === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("FAIL flush_no_done dones=%0d want 0", dones);
        end
        checks++;
        if (bus.root_o !== 24'hB504F3 || bus.grs_o !== 3'b001) begin
            failures++;
            $display("FAIL flush_retain root=%h grs=%b want b504f3 001", bus.root_o, bus.grs_o);
        end
    endtask

    // Flush and start together in IDLE: nothing starts.
    task automatic test_flush_start_idle();
        int dones;
        dones = 0;
        bus.mant_i    = 24'hC80000;
        bus.exp_odd_i = 1'b0;
        bus.start_i   = 1'b1;
        bus.flush_i   = 1'b1;
        tick();
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        checks++;
        if (bus.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_start_busy busy=%b want 0", bus.busy_o);
        end
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.done_o === 1'b1) dones++;
        end
        checks++;
        if (dones != 0 || bus.root_o !== 24'hB504F3) begin
            failures++;
            $display("FAIL flush_start_no_op dones=%0d root=%h want 0 b504f3", dones, bus.root_o);
        end
    endtask

    // Reset mid-CALC clears outputs immediately, and no stale done follows.
    // A fresh request then completes.
    task automatic test_reset_mid_calc();
        int dones;
        dones = 0;
        bus.mant_i    = 24'hC80000;
        bus.exp_odd_i = 1'b0;
        bus.start_i   = 1'b1;
        tick();
        bus.start_i = 1'b0;
        for (int i = 1; i <= 12; i++) tick();
        #3 reset_i = 1'b0;
        #1;
        checks++;
        if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_ctrl busy=%b done=%b want 0 0", bus.busy_o, bus.done_o);
        end
        checks++;
        if (bus.root_o !== 24'h0 || bus.grs_o !== 3'b000) begin
            failures++;
            $display("FAIL rst_mid_data root=%h grs=%b want 000000 000", bus.root_o, bus.grs_o);
        end
        tick();
        tick();
        reset_i = 1'b1;
        for (int i = 0; i < 35; i++) begin
            tick();
            if (bus.done_o === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("FAIL rst_mid_no_done dones=%0d want 0", dones);
        end
        dones = 0;
        bus.mant_i    = 24'h800000;
        bus.exp_odd_i = 1'b1;
        bus.start_i   = 1'b1;
        tick();
        bus.start_i = 1'b0;
        for (int c = 1; c < 26; c++) begin
            tick();
            if (bus.done_o === 1'b1) dones++;
        end
        tick();
        checks++;
        if (dones != 0 || bus.done_o !== 1'b1) begin
            failures++;
            $display("FAIL rst_after_latency early=%0d done=%b want 0 1", dones, bus.done_o);
        end
        checks++;
        if (bus.root_o !== 24'hB504F3 || bus.grs_o !== 3'b001) begin
            failures++;
            $display("FAIL rst_after_result root=%h grs=%b want b504f3 001", bus.root_o, bus.grs_o);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_start_ignored();
        test_flush();
        test_flush_start_idle();
        test_reset_mid_calc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fp_sqrt_mant
